traffic_sensor_frontend: RTL and testbench
==========================================

# traffic_sensor_frontend

Upstream conditioning stage for the intersection light controller. Takes raw, bouncy vehicle-loop, pedestrian-button and emergency-beacon inputs, then debounces them. Maintains saturating 3-bit queue counts per approach and produces the `main_num`, `left_num`, `sec_num`, `p_num`, `m_emergency` and `s_emergency` signals consumed by the controller. All outputs are registered and change only on `clk` rising edges.

## Interface
- `DEB_CYC`, 3: consecutive equal samples needed to change a filtered level; legal 1..15.
- `EMG_HOLD`, 10: cycles an emergency output is held after its filtered input falls; legal 0..255.
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `main_arr`, `main_dep` in 1 each: main through-lane arrival / departure loop, raw.
- `left_arr`, `left_dep` in 1 each: main left-turn lane arrival / departure loop, raw.
- `sec_arr`, `sec_dep` in 1 each: secondary road arrival / departure loop, raw.
- `p_req` in 1: pedestrian push-button, raw.
- `ped_on` in 1: controller's `ped` output (walk lit); already synchronous, not debounced.
- `m_emg_in`, `s_emg_in` in 1 each: main / secondary emergency beacon detector, raw.
- `main_num`, `left_num`, `sec_num` out 3: vehicle queue counts, 0..7.
- `p_num` out 3: pending pedestrian requests, 0..7.
- `m_emergency`, `s_emergency` out 1: emergency requests to the controller.

## Operation
- Debounce applies to each of the 9 raw inputs, each independently:
  - Each input has a filtered level `f` and a 4-bit run counter.
  - When the sample differs from `f`, the counter increments; otherwise it clears.
  - When the counter reaches `DEB_CYC`, `f` toggles and the counter clears.
  - A rise of `f` is an event, registered as a one-cycle pulse.
- Vehicle counts, one per lane:
  - Arrival event alone: +1, saturating at 7.
  - Departure event alone: −1, floored at 0.
  - Both events in the same cycle: count unchanged, including at 0 and at 7.
- Pedestrian count:
  - `p_req` event: +1, saturating at 7.
  - Falling edge of `ped_on` (registered previous value 1, current 0): clear to 0.
  - Clear and `p_req` event in the same cycle: `p_num` = 1.
- Emergency, per side, 2-state FSM:
  - States: IDLE, ACTIVE.
  - IDLE→ACTIVE on rise of filtered `emg`.
  - In ACTIVE, the hold counter reloads to `EMG_HOLD` while filtered `emg` is 1.
  - In ACTIVE, the hold counter decrements while filtered `emg` is 0.
  - ACTIVE→IDLE when filtered `emg` is 0 and the counter is 0.
  - A re-rise during hold keeps ACTIVE and reloads the counter.
- Emergency outputs and priority:
  - `m_emergency` = main FSM in ACTIVE.
  - `s_emergency` = secondary FSM in ACTIVE and main FSM not in ACTIVE.
  - The outputs are never both 1.
  - The secondary FSM keeps running while masked; `s_emergency` reappears once main returns to IDLE, if secondary is still ACTIVE.

## Timing
- Reset values: every output, filtered level, run counter, hold counter and the `ped_on` history register are 0; both FSMs are in IDLE.
- A raw input held high through reset needs `DEB_CYC` post-reset samples before it registers.
- Count latency: with the raw input first sampled high at edge k and held, `f` rises at edge k+`DEB_CYC`−1 and the count updates at edge k+`DEB_CYC`.
  - Example: `DEB_CYC`=3, first high sample at edge 1 → count changes at edge 4.
- Emergency assert: `m_emergency`/`s_emergency` rise at the same edge the corresponding count would update.
- Emergency release:
  - Filtered `emg` falls at edge j; the output stays 1 through edge j+`EMG_HOLD` and is 0 after edge j+`EMG_HOLD`+1.
  - `EMG_HOLD`=0 → output drops at edge j+1.
- `p_num` clear latency: `ped_on` sampled 0 at edge t after 1 at edge t−1 → `p_num` is 0 after edge t.
- Glitch rejection: a raw pulse shorter than `DEB_CYC` samples produces no event and no count change.
- `rst` mid-operation: all state returns to reset values on that edge; pending events are discarded.

## Configuration
- `SENSOR_SYNC_EN`:
  - Defined: every raw input (not `ped_on`) passes through a 2-flop synchronizer, also cleared by `rst`, before debounce. All raw-input latencies above grow by exactly 2 cycles.
  - Undefined: raw inputs are sampled directly by the debounce logic.

## Test plan
- `DEB_CYC`=3: `main_arr` high 2 cycles, then low → `main_num` stays 0. Then high 3 cycles → `main_num`=1 exactly 4 edges after its first high sample.
- 9 clean `sec_arr` pulses → `sec_num` saturates at 7. Then simultaneous `sec_arr`/`sec_dep` pulses → stays 7. Then 8 `sec_dep` pulses → floors at 0.
- 3 `p_req` presses → `p_num`=3. `ped_on` 1→0 → `p_num`=0 on the next edge. A `p_req` event coincident with the `ped_on` fall → `p_num`=1.
- `s_emg_in` active → `s_emergency`=1. Then `m_emg_in` active → `m_emergency`=1 and `s_emergency`=0 at the same edge. Release `m_emg_in` with `EMG_HOLD`=10 → `m_emergency` drops 11 edges after the filtered fall, and `s_emergency` returns on that same edge.
- `rst` asserted one cycle mid-debounce and mid-hold → all outputs 0 next edge. A held raw input re-registers only after `DEB_CYC` further samples.
- With `SENSOR_SYNC_EN` defined, repeat the first scenario → count change occurs at edge 6 instead of edge 4.

Source files
------------

// File: rtl/traffic_sensor_frontend.sv
// Sensor conditioning for the intersection controller: debounce, lane queue counts,
// pedestrian request count and emergency hold/priority. Optional input sync: SENSOR_SYNC_EN.
module traffic_sensor_frontend #(
  parameter int DEB_CYC  = 3,
  parameter int EMG_HOLD = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_arr,
  input  logic       main_dep,
  input  logic       left_arr,
  input  logic       left_dep,
  input  logic       sec_arr,
  input  logic       sec_dep,
  input  logic       p_req,
  input  logic       ped_on,
  input  logic       m_emg_in,
  input  logic       s_emg_in,
  output logic [2:0] main_num,
  output logic [2:0] left_num,
  output logic [2:0] sec_num,
  output logic [2:0] p_num,
  output logic       m_emergency,
  output logic       s_emergency,
  output logic [1:0] emg_dbg
);

  localparam int          NIN       = 9;
  localparam int          I_MARR    = 0;
  localparam int          I_MDEP    = 1;
  localparam int          I_LARR    = 2;
  localparam int          I_LDEP    = 3;
  localparam int          I_SARR    = 4;
  localparam int          I_SDEP    = 5;
  localparam int          I_PREQ    = 6;
  localparam int          I_MEMG    = 7;
  localparam int          I_SEMG    = 8;
  localparam logic [3:0]  DEB_LIM   = 4'(DEB_CYC);
  localparam logic [7:0]  HOLD_INIT = 8'(EMG_HOLD);

  typedef enum logic {IDLE, ACTIVE} emg_state_t;

  logic [NIN-1:0] raw;
  logic [NIN-1:0] sampled;

  assign raw = {s_emg_in, m_emg_in, p_req, sec_dep, sec_arr,
                left_dep, left_arr, main_dep, main_arr};

`ifdef SENSOR_SYNC_EN
  logic [NIN-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign sampled = sync2;
`else
  assign sampled = raw;
`endif

  // Debounce: a run of DEB_CYC samples disagreeing with the filtered level flips it.
  logic [NIN-1:0] filt, filt_nxt, ev;
  logic [3:0]     run_cnt [NIN];
  logic [3:0]     run_nxt [NIN];

  always_comb begin
    filt_nxt = filt;
    for (int i = 0; i < NIN; i++) begin
      run_nxt[i] = '0;
      if (sampled[i] != filt[i]) begin
        if (run_cnt[i] + 4'd1 == DEB_LIM) filt_nxt[i] = ~filt[i];
        else                              run_nxt[i] = run_cnt[i] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      ev   <= '0;
      for (int i = 0; i < NIN; i++) run_cnt[i] <= '0;
    end else begin
      filt <= filt_nxt;
      ev   <= filt_nxt & ~filt;
      for (int i = 0; i < NIN; i++) run_cnt[i] <= run_nxt[i];
    end
  end

  function automatic logic [2:0] lane_next(input logic [2:0] c, input logic a, input logic d);
    logic [2:0] r;
    r = c;
    if (a && !d && c != 3'd7)      r = c + 3'd1;
    else if (d && !a && c != 3'd0) r = c - 3'd1;
    return r;
  endfunction

  logic ped_prev;
  logic ped_clr;

  assign ped_clr = ped_prev & ~ped_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_num <= '0;
      left_num <= '0;
      sec_num  <= '0;
      p_num    <= '0;
      ped_prev <= 1'b0;
    end else begin
      main_num <= lane_next(main_num, ev[I_MARR], ev[I_MDEP]);
      left_num <= lane_next(left_num, ev[I_LARR], ev[I_LDEP]);
      sec_num  <= lane_next(sec_num,  ev[I_SARR], ev[I_SDEP]);
      ped_prev <= ped_on;
      if (ped_clr)                         p_num <= {2'b00, ev[I_PREQ]};
      else if (ev[I_PREQ] && p_num != 3'd7) p_num <= p_num + 3'd1;
    end
  end

  // Emergency FSMs: hold counter reloads while the beacon is present, counts down after.
  emg_state_t m_state, m_state_nxt, s_state, s_state_nxt;
  logic [7:0] m_hold, m_hold_nxt, s_hold, s_hold_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_state     <= IDLE;
      s_state     <= IDLE;
      m_hold      <= '0;
      s_hold      <= '0;
      m_emergency <= 1'b0;
      s_emergency <= 1'b0;
    end else begin
      m_state     <= m_state_nxt;
      s_state     <= s_state_nxt;
      m_hold      <= m_hold_nxt;
      s_hold      <= s_hold_nxt;
      m_emergency <= (m_state_nxt == ACTIVE);
      s_emergency <= (s_state_nxt == ACTIVE) && (m_state_nxt != ACTIVE);
    end
  end

  always_comb begin
    m_state_nxt = m_state;
    m_hold_nxt  = m_hold;
    s_state_nxt = s_state;
    s_hold_nxt  = s_hold;
    case (m_state)
      IDLE: if (ev[I_MEMG]) begin
        m_state_nxt = ACTIVE;
        m_hold_nxt  = HOLD_INIT;
      end
      ACTIVE: begin
        if (filt[I_MEMG])       m_hold_nxt  = HOLD_INIT;
        else if (m_hold != '0)  m_hold_nxt  = m_hold - 8'd1;
        else                    m_state_nxt = IDLE;
      end
      default: m_state_nxt = IDLE;
    endcase
    case (s_state)
      IDLE: if (ev[I_SEMG]) begin
        s_state_nxt = ACTIVE;
        s_hold_nxt  = HOLD_INIT;
      end
      ACTIVE: begin
        if (filt[I_SEMG])       s_hold_nxt  = HOLD_INIT;
        else if (s_hold != '0)  s_hold_nxt  = s_hold - 8'd1;
        else                    s_state_nxt = IDLE;
      end
      default: s_state_nxt = IDLE;
    endcase
  end

  assign emg_dbg = {s_state == ACTIVE, m_state == ACTIVE};

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Directed bench for traffic_sensor_frontend: debounce latency, saturation, pedestrian
// clear, emergency priority/hold and mid-run reset.
module tb_traffic_sensor_frontend;

  localparam int DEB_CYC  = 3;
  localparam int EMG_HOLD = 10;
`ifdef SENSOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [8:0] M_MARR = 9'h001;
  localparam logic [8:0] M_MDEP = 9'h002;
  localparam logic [8:0] M_LARR = 9'h004;
  localparam logic [8:0] M_LDEP = 9'h008;
  localparam logic [8:0] M_SARR = 9'h010;
  localparam logic [8:0] M_SDEP = 9'h020;
  localparam logic [8:0] M_PREQ = 9'h040;
  localparam logic [8:0] M_MEMG = 9'h080;
  localparam logic [8:0] M_SEMG = 9'h100;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] raw;
  logic       ped_on;
  logic [2:0] main_num, left_num, sec_num, p_num;
  logic       m_emergency, s_emergency;
  logic [1:0] emg_dbg;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  traffic_sensor_frontend #(.DEB_CYC(DEB_CYC), .EMG_HOLD(EMG_HOLD)) dut (
    .clk(clk), .rst(rst),
    .main_arr(raw[0]), .main_dep(raw[1]), .left_arr(raw[2]), .left_dep(raw[3]),
    .sec_arr(raw[4]), .sec_dep(raw[5]), .p_req(raw[6]), .ped_on(ped_on),
    .m_emg_in(raw[7]), .s_emg_in(raw[8]),
    .main_num(main_num), .left_num(left_num), .sec_num(sec_num), .p_num(p_num),
    .m_emergency(m_emergency), .s_emergency(s_emergency), .emg_dbg(emg_dbg)
  );

  // Advance n rising edges; inputs are driven and outputs read 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [8:0] m);
    raw = raw | m;
    tick(DEB_CYC + 1);
    raw = raw & ~m;
    tick(DEB_CYC + 3 + LAT);
  endtask

  task automatic chk3(input string name, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b", name, got, want);
    end
  endtask

  task automatic test_reset;
    raw = '0;
    ped_on = 1'b0;
    rst = 1'b1;
    tick(3);
    chk3("rst_main", main_num, 3'd0);
    chk3("rst_left", left_num, 3'd0);
    chk3("rst_sec", sec_num, 3'd0);
    chk3("rst_p", p_num, 3'd0);
    chk1("rst_memg", m_emergency, 1'b0);
    chk1("rst_semg", s_emergency, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_latency;
    raw[0] = 1'b1;
    tick(2);
    raw[0] = 1'b0;
    tick(8);
    chk3("glitch_main", main_num, 3'd0);
    raw[0] = 1'b1;
    tick(3);
    raw[0] = 1'b0;
    tick(LAT);
    chk3("lat_before", main_num, 3'd0);
    tick(1);
    chk3("lat_edge", main_num, 3'd1);
    tick(8);
    press(M_MDEP);
    chk3("main_dep", main_num, 3'd0);
    press(M_LARR);
    press(M_LARR);
    chk3("left_two", left_num, 3'd2);
    press(M_LDEP);
    chk3("left_dep", left_num, 3'd1);
  endtask

  task automatic test_saturation;
    press(M_SARR);
    chk3("sec_one", sec_num, 3'd1);
    for (int i = 0; i < 8; i++) press(M_SARR);
    chk3("sec_sat", sec_num, 3'd7);
    press(M_SARR | M_SDEP);
    chk3("sec_both_7", sec_num, 3'd7);
    for (int i = 0; i < 8; i++) press(M_SDEP);
    chk3("sec_floor", sec_num, 3'd0);
    press(M_SARR | M_SDEP);
    chk3("sec_both_0", sec_num, 3'd0);
  endtask

  task automatic test_ped;
    for (int i = 0; i < 3; i++) press(M_PREQ);
    chk3("ped_three", p_num, 3'd3);
    ped_on = 1'b1;
    tick(3);
    chk3("ped_on_hold", p_num, 3'd3);
    ped_on = 1'b0;
    tick(1);
    chk3("ped_clear", p_num, 3'd0);
    press(M_PREQ);
    press(M_PREQ);
    chk3("ped_two", p_num, 3'd2);
    ped_on = 1'b1;
    raw = raw | M_PREQ;
    tick(3 + LAT);
    chk3("ped_pre_coinc", p_num, 3'd2);
    ped_on = 1'b0;
    tick(1);
    chk3("ped_coinc", p_num, 3'd1);
    raw = raw & ~M_PREQ;
    tick(8);
    chk3("ped_after", p_num, 3'd1);
  endtask

  task automatic test_emergency;
    raw = raw | M_SEMG;
    tick(3 + LAT);
    chk1("s_pre", s_emergency, 1'b0);
    tick(1);
    chk1("s_on", s_emergency, 1'b1);
    raw = raw | M_MEMG;
    tick(3 + LAT);
    chk1("m_pre", m_emergency, 1'b0);
    chk1("s_pre_mask", s_emergency, 1'b1);
    tick(1);
    chk1("m_on", m_emergency, 1'b1);
    chk1("s_masked", s_emergency, 1'b0);
    chk1("s_fsm_running", emg_dbg[1], 1'b1);
    raw = raw & ~M_MEMG;
    tick(3 + LAT + EMG_HOLD);
    chk1("m_hold_last", m_emergency, 1'b1);
    chk1("s_still_masked", s_emergency, 1'b0);
    tick(1);
    chk1("m_released", m_emergency, 1'b0);
    chk1("s_returns", s_emergency, 1'b1);
    raw = raw & ~M_SEMG;
    tick(3 + LAT + EMG_HOLD);
    chk1("s_hold_last", s_emergency, 1'b1);
    tick(1);
    chk1("s_released", s_emergency, 1'b0);
  endtask

  task automatic test_reset_mid;
    raw = raw | M_MARR | M_MEMG;
    tick(3 + LAT);
    chk3("mid_main_pre", main_num, 3'd0);
    tick(1);
    chk3("mid_main_on", main_num, 3'd1);
    chk1("mid_m_on", m_emergency, 1'b1);
    raw = raw & ~M_MEMG;
    tick(5 + LAT);
    chk1("mid_m_holding", m_emergency, 1'b1);
    raw = raw | M_SARR;
    tick(1);
    rst = 1'b1;
    tick(1);
    chk3("mid_rst_main", main_num, 3'd0);
    chk3("mid_rst_left", left_num, 3'd0);
    chk3("mid_rst_p", p_num, 3'd0);
    chk1("mid_rst_m", m_emergency, 1'b0);
    chk3("mid_rst_fsm", {1'b0, emg_dbg}, 3'd0);
    rst = 1'b0;
    tick(3 + LAT);
    chk3("rearm_main_pre", main_num, 3'd0);
    chk3("rearm_sec_pre", sec_num, 3'd0);
    tick(1);
    chk3("rearm_main", main_num, 3'd1);
    chk3("rearm_sec", sec_num, 3'd1);
    chk1("rearm_m_off", m_emergency, 1'b0);
    raw = '0;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_saturation();
    test_ped();
    test_emergency();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
